// File: rtl/gate_truth_table_sequencer_if.sv
// Harness-side bundle for gate_truth_table_sequencer: run control, gate stimulus/response and verdict.
// master = self-check harness / gate side, slave = sequencer.
interface gate_truth_table_sequencer_if;
  logic       start;
  logic       dut_out;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [2:0] err_count;

  modport master (
    output start, dut_out,
    input  dut_a, dut_b, busy, done, pass, fail_mask, err_count
  );

  modport slave (
    input  start, dut_out,
    output dut_a, dut_b, busy, done, pass, fail_mask, err_count
  );
endinterface

// File: rtl/gate_truth_table_sequencer.sv
// Walks a 2-input gate through vectors 00..11, samples after a settle time and checks against EXPECTED.
// Optional macro STOP_ON_FAIL_EN: finish the run at the first mismatching vector.
module gate_truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = 4'b0111
) (
  input logic                         clk,
  input logic                         rst_n,
  gate_truth_table_sequencer_if.slave bus
);

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic [2:0] err_count_q, err_count_d;
  logic       mismatch;
  logic       last_vec;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ab_d        = ab_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    err_count_d = err_count_q;
    mismatch    = 1'b0;
    last_vec    = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d     = APPLY;
          idx_d       = '0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          fail_mask_d = '0;
          err_count_d = '0;
        end
      end

      APPLY: begin
        ab_d    = idx_q;
        cnt_d   = CNT_INIT;
        state_d = SETTLE;
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      SAMPLE: begin
        mismatch = (bus.dut_out != EXPECTED[idx_q]);
        if (mismatch) begin
          fail_mask_d[idx_q] = 1'b1;
          err_count_d        = err_count_q + 3'd1;
        end
`ifdef STOP_ON_FAIL_EN
        last_vec = (idx_q == 2'd3) || mismatch;
`else
        last_vec = (idx_q == 2'd3);
`endif
        // done/pass are registered, so they are loaded on the edge entering DONE
        // using the mask that already includes this sample.
        if (last_vec) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (fail_mask_d == '0);
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = APPLY;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      ab_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ab_q        <= ab_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.dut_a     = ab_q[1];
  assign bus.dut_b     = ab_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_mask_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Bench for gate_truth_table_sequencer: behavioural gate models drive dut_out; a run-timeline model
// predicts every output each cycle, and directed runs pin the model with literal expectations.
module tb_gate_truth_table_sequencer;

  localparam int         S   = 2;
  localparam int         P   = S + 2;
  localparam logic [3:0] EXP = 4'b0111;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   mode_sel = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [1:0] ab_trace [0:127];

  gate_truth_table_sequencer_if bus_if ();

  gate_truth_table_sequencer #(
    .SETTLE_CYCLES(S),
    .EXPECTED     (EXP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // modes: 0 NAND, 1 stuck-at-1, 2 AND, 3 stuck-at-0
  function automatic logic gate_fn(input int m, input logic [1:0] v);
    case (m)
      0:       return ~(v[1] & v[0]);
      1:       return 1'b1;
      2:       return v[1] & v[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic mism(input int m, input int v);
    logic [1:0] vv;
    vv = v[1:0];
    return gate_fn(m, vv) != EXP[vv];
  endfunction

  function automatic int nvec(input int m);
`ifdef STOP_ON_FAIL_EN
    for (int v = 0; v < 4; v++) begin
      if (mism(m, v)) return v + 1;
    end
`endif
    return 4;
  endfunction

  always_comb bus_if.dut_out = gate_fn(mode_sel, {bus_if.dut_a, bus_if.dut_b});

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: t = edges since the accepting edge of the latest run.
  logic       have_run = 1'b0;
  logic       running  = 1'b0;
  int         t        = 0;
  int         run_mode = 0;
  logic [1:0] prev_ab  = 2'b00;

  int         m_nv, m_L, m_q;
  logic [1:0] e_ab;
  logic       e_busy, e_done, e_pass;
  logic [3:0] e_mask;
  logic [2:0] e_err;

  always_comb begin
    m_nv   = nvec(run_mode);
    m_L    = m_nv * P;
    m_q    = 0;
    e_ab   = 2'b00;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_pass = 1'b0;
    e_mask = 4'b0000;
    e_err  = 3'd0;
    if (have_run) begin
      e_busy = running;
      e_done = running && (t == m_L);
      if (t == 0) begin
        e_ab = prev_ab;
      end else begin
        m_q = (t - 1) / P;
        if (m_q > m_nv - 1) m_q = m_nv - 1;
        e_ab = m_q[1:0];
      end
      for (int v = 0; v < 4; v++) begin
        if (v < m_nv && (v + 1) * P <= t && mism(run_mode, v)) begin
          e_mask[v] = 1'b1;
          e_err     = e_err + 3'd1;
        end
      end
      e_pass = (t >= m_L) && (e_mask == 4'b0000);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_run <= 1'b0;
      running  <= 1'b0;
      t        <= 0;
      run_mode <= 0;
      prev_ab  <= 2'b00;
    end else if (!running && bus_if.start) begin
      have_run <= 1'b1;
      running  <= 1'b1;
      t        <= 0;
      run_mode <= mode_sel;
      prev_ab  <= e_ab;
    end else if (running) begin
      t <= t + 1;
      if (t + 1 > m_L) running <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_ab",   int'({bus_if.dut_a, bus_if.dut_b}), int'(e_ab));
    chk("model_busy", int'(bus_if.busy),      int'(e_busy));
    chk("model_done", int'(bus_if.done),      int'(e_done));
    chk("model_pass", int'(bus_if.pass),      int'(e_pass));
    chk("model_mask", int'(bus_if.fail_mask), int'(e_mask));
    chk("model_err",  int'(bus_if.err_count), int'(e_err));
  end

  // Wait (bounded) for done, counting edges after the accepting edge; traces dut_a/dut_b.
  task automatic wait_done(input bit repulse, output int n);
    n = 0;
    while (!bus_if.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      ab_trace[n] = {bus_if.dut_a, bus_if.dut_b};
      bus_if.start = repulse && (n == 4 || n == 9);
    end
    bus_if.start = 1'b0;
  endtask

  task automatic do_run(input string tag, input int mode, input int x_mask, input int x_err,
                        input int x_pass, input int x_edge, input bit repulse);
    int n;
    mode_sel = mode;
    @(posedge clk);
    #1 bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    wait_done(repulse, n);
    chk({tag, "_done_edge"}, n, x_edge);
    chk({tag, "_mask"},      int'(bus_if.fail_mask), x_mask);
    chk({tag, "_err"},       int'(bus_if.err_count), x_err);
    chk({tag, "_pass"},      int'(bus_if.pass),      x_pass);
    chk({tag, "_busy_done"}, int'(bus_if.busy),      1);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, int'(bus_if.done), 0);
    chk({tag, "_busy_after"}, int'(bus_if.busy), 0);
  endtask

  initial begin
    int n;
    bus_if.start = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_ab",   int'({bus_if.dut_a, bus_if.dut_b}), 0);
    chk("rst_err",  int'(bus_if.err_count), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // NAND, clean run; vectors step 00,01,10,11 every P edges
    do_run("nand", 0, 4'b0000, 0, 1, 16, 1'b0);
    chk("nand_ab_e1",  int'(ab_trace[1]),  0);
    chk("nand_ab_e4",  int'(ab_trace[4]),  0);
    chk("nand_ab_e5",  int'(ab_trace[5]),  1);
    chk("nand_ab_e9",  int'(ab_trace[9]),  2);
    chk("nand_ab_e13", int'(ab_trace[13]), 3);
    chk("nand_ab_hold", int'({bus_if.dut_a, bus_if.dut_b}), 3);

    // stuck-at-1 fails only vector 3
    do_run("stuck1", 1, 4'b1000, 1, 0, 16, 1'b0);

`ifdef STOP_ON_FAIL_EN
    do_run("and", 2, 4'b0001, 1, 0, 4, 1'b0);
    do_run("stuck0", 3, 4'b0001, 1, 0, 4, 1'b0);
    chk("stuck0_ab_stay", int'({bus_if.dut_a, bus_if.dut_b}), 0);
`else
    do_run("and", 2, 4'b1111, 4, 0, 16, 1'b0);
    do_run("stuck0", 3, 4'b0111, 3, 0, 16, 1'b0);
`endif

    // reset during SETTLE of vector 2
    mode_sel = 0;
    @(posedge clk);
    #1 bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_ab", int'({bus_if.dut_a, bus_if.dut_b}), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ab",   int'({bus_if.dut_a, bus_if.dut_b}), 0);
    chk("mid_rst_busy", int'(bus_if.busy), 0);
    chk("mid_rst_done", int'(bus_if.done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", int'(bus_if.busy), 0);
    do_run("after_rst", 0, 4'b0000, 0, 1, 16, 1'b0);

    // start re-pulsed mid-run is ignored
    do_run("repulse", 0, 4'b0000, 0, 1, 16, 1'b1);

    // start held high: one IDLE cycle between runs
    mode_sel = 0;
    @(posedge clk);
    #1 bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (!bus_if.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("held_done_edge", n, 16);
    @(posedge clk);
    #1;
    chk("held_busy_gap", int'(bus_if.busy), 0);
    @(posedge clk);
    #1;
    chk("held_busy_rearm", int'(bus_if.busy), 1);
    chk("held_ab_pre_apply", int'({bus_if.dut_a, bus_if.dut_b}), 3);
    bus_if.start = 1'b0;
    @(posedge clk);
    #1;
    chk("held_second_apply", int'({bus_if.dut_a, bus_if.dut_b}), 0);
    n = 0;
    while (!bus_if.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("held_second_done", n, 15);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
